spartan6_dsp48a1: RTL and testbench

- Behavioural model of the Spartan-6 DSP48A1 slice: 18-bit pre-adder/subtracter, 18x18 multiplier, and 48-bit post-adder/subtracter with carry.
- Optional pipeline registers on every path, controlled by parameters.
- Serves as the arithmetic datapath for filter and MAC blocks; cascade ports BCIN/BCOUT and PCIN/PCOUT chain slices together.

---
 rtl/spartan6_dsp48a1_pkg.sv | 30 +++
 rtl/spartan6_dsp48a1_if.sv | 37 +++
 rtl/spartan6_dsp48a1_dsp_pipe_reg.sv | 36 +++
 rtl/spartan6_dsp48a1.sv | 115 +++++++++++
 tb/tb_spartan6_dsp48a1.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spartan6_dsp48a1_pkg.sv
// -----------------------------------------------------------------------------
// spartan6_dsp48a1_pkg
// Shared constants for the DSP48A1 slice model: OPMODE bit positions and the
// X / Z post-adder mux select encodings.
// -----------------------------------------------------------------------------
package spartan6_dsp48a1_pkg;

   // OPMODE bit positions (meaningful only after the OPMODE stage)
   localparam int OP_X_LO     = 0;  // OPMODE[1:0] : X mux select
   localparam int OP_Z_LO     = 2;  // OPMODE[3:2] : Z mux select
   localparam int OP_B1_PRE   = 4;  // 1 = pre-adder result into B1, 0 = B0 direct
   localparam int OP_CIN      = 5;  // carry-in source when CARRYINSEL = "OPMODE5"
   localparam int OP_PRE_SUB  = 6;  // 1 = pre-adder computes D - B0
   localparam int OP_POST_SUB = 7;  // 1 = post-adder computes Z - (X + CIN)

   typedef enum logic [1:0] {
      X_ZERO = 2'b00,
      X_M    = 2'b01,
      X_P    = 2'b10,
      X_DAB  = 2'b11   // {D[11:0], A1, B1}
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'b00,
      Z_PCIN = 2'b01,
      Z_P    = 2'b10,
      Z_C    = 2'b11
   } z_sel_e;

endpackage

// File: rtl/spartan6_dsp48a1_if.sv
// -----------------------------------------------------------------------------
// spartan6_dsp48a1_if
// Bundles the data, control and result signals of one DSP48A1 slice.
//   master : drives operands / OPMODE / RST* / CE*, receives results
//   slave  : the slice itself
// Data in : A, B, D, BCIN (18b), C, PCIN (48b), CARRYIN, OPMODE (8b)
// Control : RSTx synchronous clears, CEx clock enables, per register group
// Data out: BCOUT (18b), M (36b), P / PCOUT (48b), CARRYOUT / CARRYOUTF
// There is no handshake: the slice consumes its inputs every enabled clock
// and results are valid a fixed number of clocks later.
// -----------------------------------------------------------------------------
interface spartan6_dsp48a1_if;
   logic [17:0] A, B, D, BCIN;
   logic [47:0] C, PCIN;
   logic        CARRYIN;
   logic [7:0]  OPMODE;
   logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
   logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
   logic [17:0] BCOUT;
   logic [35:0] M;
   logic [47:0] P, PCOUT;
   logic        CARRYOUT, CARRYOUTF;

   modport master (
      output A, B, D, BCIN, C, PCIN, CARRYIN, OPMODE,
      output RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
      output CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
      input  BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
   );

   modport slave (
      input  A, B, D, BCIN, C, PCIN, CARRYIN, OPMODE,
      input  RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
      input  CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
      output BCOUT, M, P, PCOUT, CARRYOUT, CARRYOUTF
   );
endinterface

// File: rtl/spartan6_dsp48a1_dsp_pipe_reg.sv
// -----------------------------------------------------------------------------
// dsp_pipe_reg
// One optional pipeline stage of the slice.
//   EN = 1 : register; rst_n clears asynchronously, i_rst clears synchronously
//            (wins over i_ce), i_ce loads i_d, otherwise hold.
//   EN = 0 : plain wire from i_d to o_q.
// Ports: clk, rst_n, i_rst, i_ce, i_d[WIDTH], o_q[WIDTH]
// -----------------------------------------------------------------------------
module dsp_pipe_reg #(
   parameter int WIDTH = 18,
   parameter int EN    = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_rst,
   input  logic             i_ce,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   generate
      if (EN != 0) begin : g_reg
         logic [WIDTH-1:0] r_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     r_q <= '0;
            else if (i_rst) r_q <= '0;
            else if (i_ce)  r_q <= i_d;
         end
         assign o_q = r_q;
      end else begin : g_wire
         // Clock/control pins are intentionally dead in bypass mode.
         logic w_unused;
         assign w_unused = ^{clk, rst_n, i_rst, i_ce};
         assign o_q      = i_d;
      end
   endgenerate
endmodule

// File: rtl/spartan6_dsp48a1.sv
// -----------------------------------------------------------------------------
// spartan6_dsp48a1
// Behavioural DSP48A1 slice: 18-bit pre-adder/subtracter, unsigned 18x18
// multiplier and 48-bit post-adder/subtracter with carry, each path with an
// optional pipeline stage selected by parameter.
// Ports: clk, rst_n (async active-low), io_bus (spartan6_dsp48a1_if.slave)
// Default latency operands -> P is 4 clocks (D, B1, M, P stages).
// -----------------------------------------------------------------------------
module spartan6_dsp48a1
   import spartan6_dsp48a1_pkg::*;
#(
   parameter int    A0REG       = 0,
   parameter int    A1REG       = 1,
   parameter int    B0REG       = 0,
   parameter int    B1REG       = 1,
   parameter int    CREG        = 1,
   parameter int    DREG        = 1,
   parameter int    MREG        = 1,
   parameter int    PREG        = 1,
   parameter int    CARRYINREG  = 1,
   parameter int    CARRYOUTREG = 1,
   parameter int    OPMODEREG   = 1,
   parameter string CARRYINSEL  = "OPMODE5",
   parameter string B_INPUT     = "DIRECT"
) (
   input logic                 clk,
   input logic                 rst_n,
   spartan6_dsp48a1_if.slave   io_bus
);
   localparam bit USE_CIN_PORT = (CARRYINSEL == "CARRYIN");
   localparam bit USE_BCIN     = (B_INPUT == "CASCADE");

   logic [7:0]  w_op;
   logic [17:0] w_a0, w_a1, w_b_src, w_b0, w_b1, w_b1_in, w_d, w_pre;
   logic [35:0] w_prod, w_m;
   logic [47:0] w_c, w_x, w_z, w_p;
   logic        w_cin_src, w_cin, w_co;
   logic [48:0] w_sum;

   dsp_pipe_reg #(.WIDTH(8),  .EN(OPMODEREG)) u_op (.clk, .rst_n,
      .i_rst(io_bus.RSTOPMODE), .i_ce(io_bus.CEOPMODE), .i_d(io_bus.OPMODE), .o_q(w_op));

   dsp_pipe_reg #(.WIDTH(18), .EN(A0REG)) u_a0 (.clk, .rst_n,
      .i_rst(io_bus.RSTA), .i_ce(io_bus.CEA), .i_d(io_bus.A), .o_q(w_a0));
   dsp_pipe_reg #(.WIDTH(18), .EN(A1REG)) u_a1 (.clk, .rst_n,
      .i_rst(io_bus.RSTA), .i_ce(io_bus.CEA), .i_d(w_a0), .o_q(w_a1));

   assign w_b_src = USE_BCIN ? io_bus.BCIN : io_bus.B;

   dsp_pipe_reg #(.WIDTH(18), .EN(B0REG)) u_b0 (.clk, .rst_n,
      .i_rst(io_bus.RSTB), .i_ce(io_bus.CEB), .i_d(w_b_src), .o_q(w_b0));
   dsp_pipe_reg #(.WIDTH(18), .EN(DREG)) u_d (.clk, .rst_n,
      .i_rst(io_bus.RSTD), .i_ce(io_bus.CED), .i_d(io_bus.D), .o_q(w_d));

   // Pre-adder wraps modulo 2^18.
   assign w_pre   = w_op[OP_PRE_SUB] ? (w_d - w_b0) : (w_d + w_b0);
   assign w_b1_in = w_op[OP_B1_PRE]  ? w_pre : w_b0;

   dsp_pipe_reg #(.WIDTH(18), .EN(B1REG)) u_b1 (.clk, .rst_n,
      .i_rst(io_bus.RSTB), .i_ce(io_bus.CEB), .i_d(w_b1_in), .o_q(w_b1));

   assign w_prod = 36'(w_a1) * 36'(w_b1);

   dsp_pipe_reg #(.WIDTH(36), .EN(MREG)) u_m (.clk, .rst_n,
      .i_rst(io_bus.RSTM), .i_ce(io_bus.CEM), .i_d(w_prod), .o_q(w_m));
   dsp_pipe_reg #(.WIDTH(48), .EN(CREG)) u_c (.clk, .rst_n,
      .i_rst(io_bus.RSTC), .i_ce(io_bus.CEC), .i_d(io_bus.C), .o_q(w_c));

   always_comb begin
      w_x = '0;
      case (x_sel_e'(w_op[OP_X_LO +: 2]))
         X_ZERO:  w_x = '0;
         X_M:     w_x = {12'd0, w_m};
         X_P:     w_x = w_p;
         X_DAB:   w_x = {w_d[11:0], w_a1, w_b1};
         default: w_x = '0;
      endcase
   end

   always_comb begin
      w_z = '0;
      case (z_sel_e'(w_op[OP_Z_LO +: 2]))
         Z_ZERO:  w_z = '0;
         Z_PCIN:  w_z = io_bus.PCIN;
         Z_P:     w_z = w_p;
         Z_C:     w_z = w_c;
         default: w_z = '0;
      endcase
   end

   assign w_cin_src = USE_CIN_PORT ? io_bus.CARRYIN : w_op[OP_CIN];

   dsp_pipe_reg #(.WIDTH(1), .EN(CARRYINREG)) u_cin (.clk, .rst_n,
      .i_rst(io_bus.RSTCARRYIN), .i_ce(io_bus.CECARRYIN), .i_d(w_cin_src), .o_q(w_cin));

   // 49-bit post-adder: bit 48 is the carry on add and the borrow on subtract.
   always_comb begin
      if (w_op[OP_POST_SUB])
         w_sum = {1'b0, w_z} - ({1'b0, w_x} + 49'(w_cin));
      else
         w_sum = {1'b0, w_z} + {1'b0, w_x} + 49'(w_cin);
   end

   dsp_pipe_reg #(.WIDTH(48), .EN(PREG)) u_p (.clk, .rst_n,
      .i_rst(io_bus.RSTP), .i_ce(io_bus.CEP), .i_d(w_sum[47:0]), .o_q(w_p));
   dsp_pipe_reg #(.WIDTH(1), .EN(CARRYOUTREG)) u_co (.clk, .rst_n,
      .i_rst(io_bus.RSTCARRYIN), .i_ce(io_bus.CECARRYIN), .i_d(w_sum[48]), .o_q(w_co));

   assign io_bus.BCOUT     = w_b1;
   assign io_bus.M         = w_m;
   assign io_bus.P         = w_p;
   assign io_bus.PCOUT     = w_p;
   assign io_bus.CARRYOUT  = w_co;
   assign io_bus.CARRYOUTF = w_co;
endmodule

// File: tb/tb_spartan6_dsp48a1.sv
// -----------------------------------------------------------------------------
// tb_spartan6_dsp48a1
// Two slices share one stimulus: dut (B_INPUT = "DIRECT") and dut_c
// (B_INPUT = "CASCADE"). Expected results are queued as
// {cascade BCOUT, BCOUT, M, P, CARRYOUT} and popped by a negedge monitor.
// -----------------------------------------------------------------------------
module tb_spartan6_dsp48a1;
  localparam int W = 121;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spartan6_dsp48a1_if bus ();
  spartan6_dsp48a1_if bus_c ();

  spartan6_dsp48a1 dut (.clk(clk), .rst_n(rst_n), .io_bus(bus.slave));
  spartan6_dsp48a1 #(.B_INPUT("CASCADE")) dut_c (.clk(clk), .rst_n(rst_n), .io_bus(bus_c.slave));

  assign bus_c.A = bus.A;             assign bus_c.B = bus.B;
  assign bus_c.D = bus.D;             assign bus_c.BCIN = bus.BCIN;
  assign bus_c.C = bus.C;             assign bus_c.PCIN = bus.PCIN;
  assign bus_c.CARRYIN = bus.CARRYIN; assign bus_c.OPMODE = bus.OPMODE;
  assign bus_c.RSTA = bus.RSTA;       assign bus_c.RSTB = bus.RSTB;
  assign bus_c.RSTC = bus.RSTC;       assign bus_c.RSTD = bus.RSTD;
  assign bus_c.RSTM = bus.RSTM;       assign bus_c.RSTP = bus.RSTP;
  assign bus_c.RSTCARRYIN = bus.RSTCARRYIN;
  assign bus_c.RSTOPMODE = bus.RSTOPMODE;
  assign bus_c.CEA = bus.CEA;         assign bus_c.CEB = bus.CEB;
  assign bus_c.CEC = bus.CEC;         assign bus_c.CED = bus.CED;
  assign bus_c.CEM = bus.CEM;         assign bus_c.CEP = bus.CEP;
  assign bus_c.CECARRYIN = bus.CECARRYIN;
  assign bus_c.CEOPMODE = bus.CEOPMODE;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           req_cnt = 0;
  int           done_cnt = 0;
  int           total = 0;
  int           bad = 0;

  function automatic logic [W-1:0] pack(logic [17:0] cbc, logic [17:0] bc, logic [35:0] m,
                                        logic [47:0] p, logic co);
    return {cbc, bc, m, p, co};
  endfunction

  // Reference: spec arithmetic for a slice whose inputs have been held long
  // enough to flush the pipeline (no P feedback selected).
  function automatic logic [17:0] ref_b1(logic [17:0] b, logic [17:0] d, logic [7:0] op);
    logic [17:0] pre;
    pre = op[6] ? d - b : d + b;
    return op[4] ? pre : b;
  endfunction

  function automatic logic [W-1:0] ref_model(logic [17:0] a, logic [17:0] b, logic [17:0] d,
                                             logic [17:0] bcin, logic [47:0] c,
                                             logic [47:0] pcin, logic [7:0] op);
    logic [17:0] b1;
    logic [35:0] m;
    logic [47:0] x, z;
    logic [48:0] full;
    b1 = ref_b1(b, d, op);
    m  = 36'(a) * 36'(b1);
    case (op[1:0])
      2'd1:    x = {12'd0, m};
      2'd3:    x = {d[11:0], a, b1};
      default: x = 48'd0;
    endcase
    case (op[3:2])
      2'd1:    z = pcin;
      2'd3:    z = c;
      default: z = 48'd0;
    endcase
    if (op[7]) full = 49'(z) - 49'(x) - 49'(op[5]);
    else       full = 49'(z) + 49'(x) + 49'(op[5]);
    return pack(ref_b1(bcin, d, op), b1, m, full[47:0], full[48]);
  endfunction

  // ---------------- monitor ----------------
  task automatic cmp(string name, string field, logic [47:0] act, logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s act=%0h exp=%0h", name, field, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    string        nm;
    if (done_cnt < req_cnt) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      done_cnt++;
      cmp(nm, "bcout_casc", 48'(bus_c.BCOUT), 48'(e[120:103]));
      cmp(nm, "bcout",      48'(bus.BCOUT),   48'(e[102:85]));
      cmp(nm, "m",          48'(bus.M),       48'(e[84:49]));
      cmp(nm, "p",          bus.P,            e[48:1]);
      cmp(nm, "pcout",      bus.PCOUT,        e[48:1]);
      cmp(nm, "carryout",   48'(bus.CARRYOUT),  48'(e[0]));
      cmp(nm, "carryoutf",  48'(bus.CARRYOUTF), 48'(e[0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_now(string name, logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(name);
    req_cnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic apply(logic [17:0] a, logic [17:0] b, logic [17:0] d, logic [17:0] bcin,
                       logic [47:0] c, logic [47:0] pcin, logic cin, logic [7:0] op);
    bus.A = a; bus.B = b; bus.D = d; bus.BCIN = bcin;
    bus.C = c; bus.PCIN = pcin; bus.CARRYIN = cin; bus.OPMODE = op;
  endtask

  task automatic set_rst(logic v);
    bus.RSTA = v; bus.RSTB = v; bus.RSTC = v; bus.RSTD = v;
    bus.RSTM = v; bus.RSTP = v; bus.RSTCARRYIN = v; bus.RSTOPMODE = v;
  endtask

  task automatic set_ce(logic v);
    bus.CEA = v; bus.CEB = v; bus.CEC = v; bus.CED = v;
    bus.CEM = v; bus.CEP = v; bus.CECARRYIN = v; bus.CEOPMODE = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]   sel3 [3];
    logic [7:0]   op;
    logic [17:0]  ra, rb, rd, rbc;
    logic [47:0]  rc, rpc;
    logic [47:0]  acc_exp;
    sel3[0] = 2'd0; sel3[1] = 2'd1; sel3[2] = 2'd3;

    apply('0, '0, '0, '0, '0, '0, 1'b0, 8'h00);
    set_rst(1'b0);
    set_ce(1'b0);
    #1 rst_n = 1'b0;
    expect_now("reset_init", '0);

    // Synchronous clear with CE high keeps everything at zero.
    rst_n = 1'b1;
    set_ce(1'b1);
    set_rst(1'b1);
    apply(18'd10, 18'd20, 18'd30, 18'd40, 48'd50, 48'd60, 1'b0, 8'h3D);
    tick(2);
    expect_now("rst_pulse0", '0);
    set_rst(1'b0);

    tick(4);
    expect_now("op3d", pack(18'd70, 18'd50, 36'd500, 48'd551, 1'b0));

    apply(18'd10, 18'd20, 18'd30, 18'd40, 48'd50, 48'd600, 1'b0, 8'hE5);
    tick(4);
    expect_now("opE5", pack(18'd40, 18'd20, 36'd200, 48'd399, 1'b0));

    apply(18'd2, 18'd3, 18'd0, 18'd7, 48'd0, 48'd0, 1'b0, 8'h01);
    tick(4);
    expect_now("cascade", pack(18'd7, 18'd3, 36'd6, 48'd6, 1'b0));

    apply(18'd1, 18'd1, 18'd0, 18'd1, 48'd0, 48'd0, 1'b0, 8'h81);
    tick(4);
    expect_now("borrow", pack(18'd1, 18'd1, 36'd1, 48'hFFFF_FFFF_FFFF, 1'b1));

    for (int i = 0; i < 24; i++) begin
      op = 8'($urandom);
      op[1:0] = sel3[$urandom_range(0, 2)];
      op[3:2] = sel3[$urandom_range(0, 2)];
      ra = 18'($urandom); rb = 18'($urandom); rd = 18'($urandom); rbc = 18'($urandom);
      rc = {16'($urandom), 32'($urandom)};
      rpc = {16'($urandom), 32'($urandom)};
      if (i < 4) begin
        ra = 18'h3FFFF; rb = 18'h3FFFF; rd = 18'h3FFFF;
      end
      apply(ra, rb, rd, rbc, rc, rpc, 1'($urandom), op);
      tick(4);
      expect_now("rand", ref_model(ra, rb, rd, rbc, rc, rpc, op));
    end

    // Asynchronous reset between clock edges clears outputs without a clock.
    apply(18'd10, 18'd20, 18'd30, 18'd40, 48'd50, 48'd60, 1'b0, 8'h3D);
    tick(4);
    rst_n = 1'b0;
    #1;
    expect_now("async_rst", '0);
    rst_n = 1'b1;

    tick(4);
    expect_now("op3d_again", pack(18'd70, 18'd50, 36'd500, 48'd551, 1'b0));
    set_rst(1'b1);
    tick(2);
    expect_now("rst_pulse1", '0);
    set_rst(1'b0);

    // Accumulator: P <- P + M with M = 1*5; P held while CEP is low.
    apply(18'd1, 18'd5, 18'd0, 18'd0, 48'd5, 48'd0, 1'b0, 8'h09);
    bus.CEP = 1'b0;
    tick(4);
    acc_exp = 48'd0;
    expect_now("acc_fill_hold", pack(18'd0, 18'd5, 36'd5, acc_exp, 1'b0));
    bus.CEP = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      acc_exp = acc_exp + 48'd5;
      expect_now("acc_step", pack(18'd0, 18'd5, 36'd5, acc_exp, 1'b0));
    end
    bus.CEP = 1'b0;
    tick(2);
    expect_now("acc_hold", pack(18'd0, 18'd5, 36'd5, acc_exp, 1'b0));

    tick(2);
    total++;
    if (exp_q.size() != 0 || done_cnt != req_cnt) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
